// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave, MSB first, with byte and frame assembly.
// All SPI inputs are asynchronous to clk and are resynchronised before use.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   SCK        SPI serial clock (async)
//   MOSI       SPI serial data (async)
//   CS         SPI chip select, active low (async)
//   byte_data  last complete byte
//   byte_valid one-cycle pulse, byte_data updated
//   word_data  last complete frame, first byte in the MSBs
//   word_valid one-cycle pulse, word_data updated
//   frame_err  one-cycle pulse, frame truncated by CS rising
//   busy       registered inverse of synchronised CS
module spi_slave_rx #(
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned MIN_HALF    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     SCK,
    input  logic                     MOSI,
    input  logic                     CS,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    output logic [8*FRAME_BYTES-1:0] word_data,
    output logic                     word_valid,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int unsigned WORD_W = 8 * FRAME_BYTES;
    localparam int unsigned BCNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);

    // Two synchroniser flops plus one edge-detect flop: a shorter SCK phase
    // could be lost between samples.
    if (MIN_HALF < 2) begin : g_min_half_check
        $error("spi_slave_rx: MIN_HALF must be at least 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e              state_q;
    logic [1:0]          sck_sync_q;
    logic [1:0]          mosi_sync_q;
    logic [1:0]          cs_sync_q;
    logic                sck_prev_q;
    logic                cs_prev_q;
    logic [1:0]          prime_q;
    logic                armed_q;
    logic [2:0]          bit_cnt_q;
    logic [BCNT_W-1:0]   byte_cnt_q;
    logic [7:0]          shift_q;
    logic [WORD_W-1:0]   frame_q;
    logic [7:0]          byte_data_q;
    logic                byte_valid_q;
    logic [WORD_W-1:0]   word_data_q;
    logic                word_valid_q;
    logic                frame_err_q;
    logic                busy_q;

    logic                sck_rise;
    logic                cs_rise;
    logic                cs_fall;
    logic [7:0]          shift_d;
    logic [WORD_W-1:0]   frame_d;

    // Edge events and next shift/frame values from synchronised inputs.
    always_comb begin
        sck_rise = sck_sync_q[1] & ~sck_prev_q;
        cs_rise  = cs_sync_q[1] & ~cs_prev_q;
        cs_fall  = ~cs_sync_q[1] & cs_prev_q;
        shift_d  = {shift_q[6:0], mosi_sync_q[1]};
        frame_d  = WORD_W'({frame_q, shift_d});
    end

    // Synchronisers, receive FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            sck_sync_q   <= 2'b00;
            mosi_sync_q  <= 2'b00;
            cs_sync_q    <= 2'b11;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            prime_q      <= 2'b00;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= '0;
            shift_q      <= 8'h00;
            frame_q      <= '0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sck_sync_q   <= {sck_sync_q[0], SCK};
            mosi_sync_q  <= {mosi_sync_q[0], MOSI};
            cs_sync_q    <= {cs_sync_q[0], CS};
            sck_prev_q   <= sck_sync_q[1];
            cs_prev_q    <= cs_sync_q[1];
            busy_q       <= ~cs_sync_q[1];
            byte_valid_q <= 1'b0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            // The synchroniser reset value of CS is not a real sample; once
            // real samples are through, require CS high before accepting a
            // fall, so a CS held low across reset cannot start a transfer.
            prime_q <= {prime_q[0], 1'b1};
            if (prime_q[1] && cs_sync_q[1]) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_q    <= RECV;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= '0;
                        shift_q    <= 8'h00;
                        frame_q    <= '0;
                    end
                end
                RECV: begin
                    // CS rise takes priority over a coincident SCK rise.
                    if (cs_rise) begin
                        state_q <= IDLE;
                        if ((bit_cnt_q != 3'd0) || (byte_cnt_q != '0)) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_data_q  <= shift_d;
                            byte_valid_q <= 1'b1;
                            frame_q      <= frame_d;
                            if (byte_cnt_q == LAST_BYTE) begin
                                word_data_q  <= frame_d;
                                word_valid_q <= 1'b1;
                                byte_cnt_q   <= '0;
                            end else begin
                                byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: directed scenarios plus random
// frames, checked against a bit-stream reference model.
module tb_spi_slave_rx;

    localparam int unsigned FB = 4;
    localparam int unsigned WW = 8 * FB;

    logic          clk;
    logic          rst;
    logic          sck;
    logic          mosi;
    logic          cs;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [WW-1:0] word_data;
    logic          word_valid;
    logic          frame_err;
    logic          busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0]    obs_bytes[$];
    logic [WW-1:0] obs_words[$];
    int            obs_err;
    bit            tx_bits[$];
    logic [WW-1:0] last_word;
    int            half;

    spi_slave_rx #(
        .FRAME_BYTES(FB),
        .MIN_HALF   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SCK       (sck),
        .MOSI      (mosi),
        .CS        (cs),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .word_data (word_data),
        .word_valid(word_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe output pulses away from the active edge.
    always @(negedge clk) begin
        if (byte_valid) obs_bytes.push_back(byte_data);
        if (word_valid) obs_words.push_back(word_data);
        if (frame_err)  obs_err = obs_err + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_bytes.delete();
        obs_words.delete();
        obs_err = 0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int k = 7; k >= 0; k--) tx_bits.push_back(v[k]);
    endtask

    task automatic clock_bit(input bit b);
        mosi = b;
        tick(half);
        sck = 1'b1;
        tick(half);
        sck = 1'b0;
    endtask

    // Send tx_bits under one CS and compare against the stream model:
    // every 8 bits form a byte, every FB bytes a word, and any leftover
    // bits or bytes at CS rise mean exactly one frame error.
    task automatic run_frame(input string tag);
        int            nb;
        int            nw;
        logic [7:0]    b;
        logic [WW-1:0] w;
        clear_obs();
        cs = 1'b0;
        tick(4);
        check({tag, " busy_hi"}, 64'(busy), 64'd1);
        foreach (tx_bits[i]) clock_bit(tx_bits[i]);
        tick(half);
        cs = 1'b1;
        tick(8);
        nb = tx_bits.size() / 8;
        nw = nb / FB;
        check({tag, " n_bytes"}, 64'(obs_bytes.size()), 64'(nb));
        check({tag, " n_words"}, 64'(obs_words.size()), 64'(nw));
        for (int i = 0; i < nb; i++) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], tx_bits[8*i+k]};
            if (i < obs_bytes.size()) check({tag, " byte"}, 64'(obs_bytes[i]), 64'(b));
        end
        for (int j = 0; j < nw; j++) begin
            w = '0;
            for (int k = 0; k < 8 * FB; k++) w = {w[WW-2:0], tx_bits[8*FB*j+k]};
            if (j < obs_words.size()) check({tag, " word"}, 64'(obs_words[j]), 64'(w));
            last_word = w;
        end
        check({tag, " frame_err"}, 64'(obs_err),
              64'((tx_bits.size() % (8 * FB)) != 0 ? 1 : 0));
        check({tag, " word_hold"}, 64'(word_data), 64'(last_word));
        check({tag, " busy_lo"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        sck       = 1'b0;
        mosi      = 1'b0;
        cs        = 1'b1;
        half      = 4;
        obs_err   = 0;
        last_word = '0;
        tick(3);
        check("rst byte_data", 64'(byte_data), 64'd0);
        check("rst word_data", 64'(word_data), 64'd0);
        check("rst valids", 64'({byte_valid, word_valid, frame_err}), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        rst = 1'b1;
        tick(6);

        // Scenario 1: single frame.
        tx_bits.delete();
        push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
        run_frame("s1");
        check("s1 word_const", 64'(last_word), 64'h12345678);

        // Scenario 2: two frames back to back under one CS.
        tx_bits.delete();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        run_frame("s2");
        check("s2 word_const", 64'(last_word), 64'h05060708);

        // Scenario 3: one byte plus 5 bits, truncated frame.
        tx_bits.delete();
        push_byte(8'hA5);
        for (int k = 0; k < 5; k++) tx_bits.push_back(k[0]);
        run_frame("s3");

        // CS glitch with no SCK activity.
        tx_bits.delete();
        run_frame("glitch");

        // Scenario 4: SCK activity with CS high is ignored.
        clear_obs();
        for (int i = 0; i < 16; i++) clock_bit(1'b1);
        tick(6);
        check("s4 n_bytes", 64'(obs_bytes.size()), 64'd0);
        check("s4 n_words", 64'(obs_words.size()), 64'd0);
        check("s4 frame_err", 64'(obs_err), 64'd0);
        check("s4 busy", 64'(busy), 64'd0);

        // Scenario 6: CS rise coincides with the 8th SCK rise of 0x3C.
        clear_obs();
        cs = 1'b0;
        tick(4);
        for (int k = 7; k >= 1; k--) begin
            logic [7:0] v;
            v = 8'h3C;
            clock_bit(v[k]);
        end
        mosi = 1'b0;
        tick(half);
        sck = 1'b1;
        cs  = 1'b1;
        tick(half);
        sck = 1'b0;
        tick(8);
        check("s6 n_bytes", 64'(obs_bytes.size()), 64'd0);
        check("s6 frame_err", 64'(obs_err), 64'd1);

        // Scenario 5: reset mid-transfer, CS held low across reset.
        clear_obs();
        cs = 1'b0;
        tick(4);
        for (int i = 0; i < 12; i++) clock_bit(1'($urandom % 2));
        rst = 1'b0;
        tick(1);
        check("s5 rst byte_data", 64'(byte_data), 64'd0);
        check("s5 rst word_data", 64'(word_data), 64'd0);
        check("s5 rst valids", 64'({byte_valid, word_valid, frame_err}), 64'd0);
        check("s5 rst busy", 64'(busy), 64'd0);
        tick(1);
        rst = 1'b1;
        last_word = '0;
        clear_obs();
        tick(6);
        for (int i = 0; i < 8; i++) clock_bit(1'b1);
        cs = 1'b1;
        tick(8);
        check("s5 stale_cs bytes", 64'(obs_bytes.size()), 64'd0);
        check("s5 stale_cs err", 64'(obs_err), 64'd0);
        tx_bits.delete();
        push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
        run_frame("s5");
        check("s5 word_const", 64'(last_word), 64'hDEADBEEF);

        // Random frames of arbitrary length and SCK rate.
        for (int t = 0; t < 10; t++) begin
            int nbits;
            half  = int'($urandom_range(4, 7));
            nbits = int'($urandom_range(0, 80));
            tx_bits.delete();
            for (int k = 0; k < nbits; k++) tx_bits.push_back(1'($urandom % 2));
            run_frame("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
